// File: rtl/hazard_forward_ctrl_pkg.sv
// rtl/hazard_forward_ctrl_pkg.sv - shared encodings for the hazard/forwarding controller
package hazard_forward_ctrl_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_MC_STALL = 2'b10
    } state_e;

endpackage

// File: rtl/fwd_src_match.sv
// rtl/fwd_src_match.sv - producer match and forward select for one ID source operand
module fwd_src_match
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0]      rs,
    input  logic [REG_AW-1:0]      idex_rd,
    input  logic                   idex_regwrite,
    input  logic                   idex_memread,
    input  logic [REG_AW-1:0]      exmem_rd,
    input  logic                   exmem_regwrite,
    input  logic [2**REG_AW-1:0]   pending,
    output logic                   lu_hit,
    output logic                   mc_hit,
    output logic [1:0]             sel
);

    logic rs_nz;
    logic ex_match;
    logic mem_match;

    assign rs_nz     = (rs != '0);
    assign ex_match  = idex_regwrite && (idex_rd == rs) && rs_nz;
    assign mem_match = exmem_regwrite && (exmem_rd == rs) && rs_nz;
    assign lu_hit    = ex_match && idex_memread;
    assign mc_hit    = rs_nz && pending[rs];

    // A load in EX has no result yet; that case stalls, so it never selects EX/MEM.
    always_comb begin
        sel = FWD_RF;
        if (ex_match && !idex_memread) begin
            sel = FWD_EXMEM;
        end else if (mem_match) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - load-use / multi-cycle stall control and EX operand forwarding
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0]         idex_rd,
    input  logic                      idex_regwrite,
    input  logic                      idex_memread,
    input  logic [REG_AW-1:0]         exmem_rd,
    input  logic                      exmem_regwrite,
    input  logic                      flush,
    input  logic                      mc_issue,
    input  logic [REG_AW-1:0]         mc_rd,
    input  logic                      mc_done,
    input  logic [REG_AW-1:0]         mc_done_rd,
    input  logic                      cnt_clr,
    output logic                      stall,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic [1:0]                state,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int NREG = 2**REG_AW;

    logic [NREG-1:0]      pending_q;
    logic [NREG-1:0]      pending_d;
    logic [NUM_SRC-1:0]   lu_hit;
    logic [NUM_SRC-1:0]   mc_hit;
    logic [NUM_SRC*2-1:0] sel_all;
    logic                 lu_haz;
    logic                 mc_haz;
    state_e               state_q;
    state_e               state_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(
            .REG_AW(REG_AW)
        ) u_match (
            .rs            (id_rs[i*REG_AW +: REG_AW]),
            .idex_rd       (idex_rd),
            .idex_regwrite (idex_regwrite),
            .idex_memread  (idex_memread),
            .exmem_rd      (exmem_rd),
            .exmem_regwrite(exmem_regwrite),
            .pending       (pending_q),
            .lu_hit        (lu_hit[i]),
            .mc_hit        (mc_hit[i]),
            .sel           (sel_all[i*2 +: 2])
        );
    end

    assign lu_haz = id_valid && (|lu_hit);
    assign mc_haz = id_valid && (|mc_hit);
    assign stall  = (lu_haz || mc_haz) && !flush;
    assign state  = state_q;

    // Set is applied after clear so an issue and a completion on the same register leave it pending.
    always_comb begin
        pending_d = pending_q;
        if (mc_done) begin
            pending_d[mc_done_rd] = 1'b0;
        end
        if (mc_issue && (mc_rd != '0)) begin
            pending_d[mc_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        state_d = ST_RUN;
        if (flush) begin
            state_d = ST_RUN;
        end else if (mc_haz) begin
            state_d = ST_MC_STALL;
        end else if (lu_haz) begin
            state_d = ST_LU_STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            state_q   <= ST_RUN;
            fwd_sel   <= '0;
            stall_cnt <= '0;
        end else begin
            pending_q <= pending_d;
            state_q   <= state_d;
            if (id_valid && !stall && !flush) begin
                fwd_sel <= sel_all;
            end else begin
                fwd_sel <= '0;
            end
            if (cnt_clr) begin
                stall_cnt <= '0;
            end else if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule
